// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the processor run controller: FSM encoding and
// default reset-hold and watchdog values.
package proc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RESET,
      ST_RUN,
      ST_SETTLE,
      ST_DONE,
      ST_TIMEOUT
   } state_e;

   localparam int unsigned CNT_W            = 16;
   localparam int unsigned RESET_CYCLES_DEF = 1;
   localparam logic [15:0] WDOG_LIMIT_DEF   = 16'hFF;

endpackage

// File: rtl/run_watchdog.sv
// RUN-cycle counter with a limit comparator; expired flags the cycle whose
// increment reaches the limit, so the owner can leave RUN on that edge.
module run_watchdog
   import proc_ctrl_pkg::*;
#(
   parameter int unsigned W = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] limit,
   output logic [W-1:0] count,
   output logic         expired
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_inc;

   assign count_inc = count_q + W'(1);
   assign count     = count_q;
   assign expired   = enable && (count_inc == limit);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_inc;
      end
   end

endmodule

// File: rtl/proc_run_ctrl.sv
// Run controller for an external single-cycle core: holds it in reset, lets it
// run to an end PC under a watchdog, then grades the data-memory pass code.
module proc_run_ctrl
   import proc_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W       = 64,
   parameter int unsigned RESET_CYCLES = RESET_CYCLES_DEF,
   parameter logic [15:0] WDOG_LIMIT   = WDOG_LIMIT_DEF
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] start_pc,
   input  logic [DATA_W-1:0] end_pc,
   input  logic [DATA_W-1:0] expected,
   input  logic [DATA_W-1:0] currentpc,
   input  logic [DATA_W-1:0] dmemout,
   output logic              proc_resetl,
   output logic [DATA_W-1:0] proc_startpc,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [15:0]       cycle_count
);

   localparam logic [15:0] RST_LAST = 16'(RESET_CYCLES - 1);

   state_e            state_q, state_d;
   logic [15:0]       rst_cnt_q;
   logic [DATA_W-1:0] spc_q, epc_q, exp_q;
   logic              done_q, pass_q, timeout_q;
   logic              start_ok, running, end_hit, wd_expired, wd_fire;

   assign start_ok = start && (state_q inside {ST_IDLE, ST_DONE, ST_TIMEOUT});
   assign running  = (state_q == ST_RUN);
   assign end_hit  = (currentpc >= epc_q);
   // End-PC outranks the watchdog when both land on the same RUN cycle.
   assign wd_fire  = running && !end_hit && wd_expired;

   run_watchdog #(.W(16)) u_wdog (
      .clk     (CLK),
      .rst     (reset),
      .clear   (start_ok),
      .enable  (running),
      .limit   (WDOG_LIMIT),
      .count   (cycle_count),
      .expired (wd_expired)
   );

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_DONE, ST_TIMEOUT: if (start) state_d = ST_RESET;
         ST_RESET:  if (rst_cnt_q == RST_LAST) state_d = ST_RUN;
         ST_RUN: begin
            if (end_hit)         state_d = ST_SETTLE;
            else if (wd_expired) state_d = ST_TIMEOUT;
         end
         ST_SETTLE: state_d = ST_DONE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      proc_resetl = (state_q == ST_RUN) || (state_q == ST_SETTLE);
      busy        = (state_q == ST_RESET) || (state_q == ST_RUN) || (state_q == ST_SETTLE);
   end

   always_ff @(posedge CLK) begin
      if (reset || (state_q != ST_RESET)) begin
         rst_cnt_q <= '0;
      end else begin
         rst_cnt_q <= rst_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         spc_q     <= '0;
         epc_q     <= '0;
         exp_q     <= '0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else if (start_ok) begin
         spc_q     <= start_pc;
         epc_q     <= end_pc;
         exp_q     <= expected;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else if (state_q == ST_SETTLE) begin
         done_q    <= 1'b1;
         pass_q    <= (dmemout == exp_q);
      end else if (wd_fire) begin
         done_q    <= 1'b1;
         pass_q    <= 1'b0;
         timeout_q <= 1'b1;
      end
   end

   assign proc_startpc = spc_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign timeout      = timeout_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Bench for proc_run_ctrl: directed runs against a PC-stepping core model,
// results checked by per-instance scoreboard monitors on the rise of done.
`timescale 1ns/1ps
module tb_proc_run_ctrl;

   typedef struct {
      string       name;
      logic        pass;
      logic        tmo;
      logic [15:0] cnt;
   } exp_t;

   logic        CLK = 1'b0;
   logic        reset = 1'b1;
   int          errors = 0;
   int          checks = 0;
   exp_t        q1[$];
   exp_t        q2[$];

   // Instance 1: default parameters
   logic        start1 = 1'b0, hang1 = 1'b0;
   logic [63:0] sp1 = '0, ep1 = '0, ex1 = '0, dmem1 = '0, pc1 = '0, cpc1;
   logic        rl1, busy1, done1, pass1, tmo1;
   logic [63:0] ps1;
   logic [15:0] cnt1;

   // Instance 2: watchdog limit of 4
   logic        start2 = 1'b0;
   logic [63:0] sp2 = '0, ep2 = '0, ex2 = '0, dmem2 = '0, pc2 = '0;
   logic        rl2, busy2, done2, pass2, tmo2;
   logic [63:0] ps2;
   logic [15:0] cnt2;

   always #5 CLK = ~CLK;

   proc_run_ctrl u_dut1 (
      .CLK(CLK), .reset(reset), .start(start1), .start_pc(sp1), .end_pc(ep1),
      .expected(ex1), .currentpc(cpc1), .dmemout(dmem1), .proc_resetl(rl1),
      .proc_startpc(ps1), .busy(busy1), .done(done1), .pass(pass1),
      .timeout(tmo1), .cycle_count(cnt1)
   );

   proc_run_ctrl #(.WDOG_LIMIT(16'd4)) u_dut2 (
      .CLK(CLK), .reset(reset), .start(start2), .start_pc(sp2), .end_pc(ep2),
      .expected(ex2), .currentpc(pc2), .dmemout(dmem2), .proc_resetl(rl2),
      .proc_startpc(ps2), .busy(busy2), .done(done2), .pass(pass2),
      .timeout(tmo2), .cycle_count(cnt2)
   );

   // Core models: PC reloads from startpc while held in reset, else steps by 4
   always @(posedge CLK) begin
      if (!rl1) pc1 <= ps1;
      else      pc1 <= pc1 + 64'd4;
      if (!rl2) pc2 <= ps2;
      else      pc2 <= pc2 + 64'd4;
   end
   assign cpc1 = hang1 ? 64'h10 : pc1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, want);
      end
   endtask

   task automatic mon_compare(input int inst, input exp_t e, input logic p, input logic t,
                              input logic [15:0] c, input logic rl, input logic b);
      check({e.name, "_pass"},    p,  e.pass);
      check({e.name, "_timeout"}, t,  e.tmo);
      check({e.name, "_count"},   c,  e.cnt);
      check({e.name, "_resetl"},  rl, 1'b0);
      check({e.name, "_busy"},    b,  1'b0);
   endtask

   logic done1_prev = 1'b0, done2_prev = 1'b0;
   always @(negedge CLK) begin
      if (done1 && !done1_prev) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut1_unexpected_done: got done=1, required no result");
         end else begin
            mon_compare(1, q1.pop_front(), pass1, tmo1, cnt1, rl1, busy1);
         end
      end
      done1_prev = done1;
   end
   always @(negedge CLK) begin
      if (done2 && !done2_prev) begin
         if (q2.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut2_unexpected_done: got done=1, required no result");
         end else begin
            mon_compare(2, q2.pop_front(), pass2, tmo2, cnt2, rl2, busy2);
         end
      end
      done2_prev = done2;
   end

   // Pulse start, then confirm the RESET cycle and the first RUN cycle
   task automatic do_start(input int inst, input logic [63:0] sp, ep, ex, dm,
                           input logic hg, input exp_t e, input bit push);
      @(negedge CLK);
      if (inst == 1) begin
         start1 = 1'b1; sp1 = sp; ep1 = ep; ex1 = ex; dmem1 = dm; hang1 = hg;
         if (push) q1.push_back(e);
      end else begin
         start2 = 1'b1; sp2 = sp; ep2 = ep; ex2 = ex; dmem2 = dm;
         if (push) q2.push_back(e);
      end
      @(negedge CLK);
      start1 = 1'b0; start2 = 1'b0;
      check({e.name, "_reset_busy"},   (inst == 1) ? busy1 : busy2, 1'b1);
      check({e.name, "_reset_resetl"}, (inst == 1) ? rl1 : rl2,     1'b0);
      check({e.name, "_startpc"},      (inst == 1) ? ps1 : ps2,     sp);
      @(negedge CLK);
      check({e.name, "_run_resetl"},   (inst == 1) ? rl1 : rl2,     1'b1);
   endtask

   task automatic wait_done(input int inst, input string name);
      int n = 0;
      while (!((inst == 1) ? done1 : done2) && n < 400) begin
         @(negedge CLK);
         n++;
      end
      check({name, "_done_in_time"}, (inst == 1) ? done1 : done2, 1'b1);
      @(negedge CLK);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_time_limit: got no finish, required finish");
      $fatal(1, "time limit");
   end

   initial begin
      int n;
      repeat (3) @(negedge CLK);
      reset = 1'b0;
      check("rst_busy",    busy1, 1'b0);
      check("rst_resetl",  rl1,   1'b0);
      check("rst_done",    done1, 1'b0);
      check("rst_pass",    pass1, 1'b0);
      check("rst_timeout", tmo1,  1'b0);
      check("rst_count",   cnt1,  16'd0);
      check("rst_startpc", ps1,   64'd0);
      check("rst2_busy",   busy2, 1'b0);

      do_start(1, 64'h0, 64'h34, 64'hF, 64'hF, 1'b0, '{"normal", 1'b1, 1'b0, 16'd14}, 1'b1);
      wait_done(1, "normal");
      check("normal_done_hold", done1, 1'b1);

      // Back-to-back run; a start pulse mid-run must be ignored
      do_start(1, 64'h38, 64'h70, 64'h123456789abcdef0, 64'h123456789abcdef0, 1'b0,
               '{"b2b", 1'b1, 1'b0, 16'd15}, 1'b1);
      repeat (2) @(negedge CLK);
      start1 = 1'b1; sp1 = 64'h999; ep1 = '0; ex1 = '0;
      @(negedge CLK);
      start1 = 1'b0;
      check("b2b_midstart_startpc", ps1,   64'h38);
      check("b2b_midstart_busy",    busy1, 1'b1);
      wait_done(1, "b2b");

      do_start(1, 64'h0, 64'h34, 64'hF, 64'hE, 1'b0, '{"failcode", 1'b0, 1'b0, 16'd14}, 1'b1);
      wait_done(1, "failcode");

      do_start(1, 64'h0, 64'h34, 64'hF, 64'hF, 1'b1, '{"hang", 1'b0, 1'b1, 16'hFF}, 1'b1);
      wait_done(1, "hang");
      repeat (3) @(negedge CLK);
      check("hang_hold_timeout", tmo1,  1'b1);
      check("hang_hold_done",    done1, 1'b1);
      check("hang_hold_resetl",  rl1,   1'b0);
      check("hang_hold_count",   cnt1,  16'hFF);

      do_start(1, 64'h40, 64'h20, 64'h5, 64'h5, 1'b0, '{"endle", 1'b1, 1'b0, 16'd1}, 1'b1);
      wait_done(1, "endle");

      // Reset (with a simultaneous start) during RUN cycle 5
      do_start(1, 64'h8, 64'h3C, 64'h1, 64'h1, 1'b0, '{"midrst", 1'b0, 1'b0, 16'd0}, 1'b0);
      n = 0;
      while (cnt1 != 16'd4 && n < 50) begin
         @(negedge CLK);
         n++;
      end
      check("midrst_reach_cycle5", cnt1, 16'd4);
      reset = 1'b1; start1 = 1'b1; sp1 = 64'h77;
      @(negedge CLK);
      reset = 1'b0; start1 = 1'b0;
      check("midrst_busy",    busy1, 1'b0);
      check("midrst_resetl",  rl1,   1'b0);
      check("midrst_done",    done1, 1'b0);
      check("midrst_pass",    pass1, 1'b0);
      check("midrst_timeout", tmo1,  1'b0);
      check("midrst_count",   cnt1,  16'd0);
      check("midrst_startpc", ps1,   64'd0);
      repeat (2) @(negedge CLK);
      check("midrst_stays_idle", busy1, 1'b0);

      // Watchdog limit 4: end-PC on cycle 4 wins; one short of end times out
      do_start(2, 64'h0, 64'h0C, 64'h3, 64'h3, 1'b0, '{"tie", 1'b1, 1'b0, 16'd4}, 1'b1);
      wait_done(2, "tie");
      do_start(2, 64'h0, 64'h10, 64'h3, 64'h3, 1'b0, '{"wd4", 1'b0, 1'b1, 16'd4}, 1'b1);
      wait_done(2, "wd4");

      repeat (2) @(negedge CLK);
      check("scoreboard1_drained", q1.size(), 0);
      check("scoreboard2_drained", q2.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/proc_run_ctrl.md
PROC_RUN_CTRL -- requirements
Module: proc_run_ctrl

Interface
REQ-001 Parameter DATA_W, default 64: width of PC and data buses.
REQ-002 Parameter RESET_CYCLES, default 1: cycles the processor is held in reset before a run.
REQ-003 Parameter WDOG_LIMIT, default 16'hFF: maximum RUN cycles before timeout.
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle run request.
REQ-007 start_pc  in  DATA_W  program start address.
REQ-008 end_pc  in  DATA_W  address that terminates the run.
REQ-009 expected  in  DATA_W  pass code expected on dmemout.
REQ-010 currentpc  in  DATA_W  PC from the singlecycle core.
REQ-011 dmemout  in  DATA_W  data-memory output from the core.
REQ-012 proc_resetl  out  1  active-low reset to the core (drives resetl).
REQ-013 proc_startpc  out  DATA_W  drives the core's startpc.
REQ-014 busy  out  1  high in RESET, RUN or SETTLE.
REQ-015 done  out  1  run finished (normally or by timeout); sticky.
REQ-016 pass  out  1  dmemout matched expected; valid while done=1.
REQ-017 timeout  out  1  watchdog expired; sticky.
REQ-018 cycle_count  out  16  RUN cycles consumed by the last or current run.

Function
REQ-019 The FSM SHALL have the states IDLE, RESET, RUN, SETTLE, DONE and TIMEOUT.
REQ-020 In IDLE, DONE or TIMEOUT, start=1 SHALL latch start_pc, end_pc and expected, clear done, pass, timeout and cycle_count, and enter RESET on the next edge.
REQ-021 While busy=1, start SHALL be ignored.
REQ-022 proc_resetl SHALL be 0 in IDLE, RESET, DONE and TIMEOUT, and 1 in RUN and SETTLE.
REQ-023 proc_startpc SHALL equal the latched start_pc at all times.
REQ-024 RESET SHALL last exactly RESET_CYCLES cycles, then enter RUN.
REQ-025 Each RUN cycle SHALL increment cycle_count.
- If currentpc >= end_pc (unsigned), the next state SHALL be SETTLE.
- Otherwise, if the incremented count equals WDOG_LIMIT, the next state SHALL be TIMEOUT.
REQ-026 When the end-PC and watchdog conditions occur in the same cycle, the end-PC condition SHALL win.
REQ-027 SETTLE SHALL last one cycle; at its edge, pass SHALL be set to (dmemout == latched expected), and the FSM SHALL enter DONE with done=1.
REQ-028 Entering TIMEOUT SHALL set timeout=1, done=1 and pass=0.
REQ-029 done, pass, timeout and cycle_count SHALL hold until the next accepted start or reset.
REQ-030 If end_pc <= start_pc, the first RUN cycle SHALL terminate the run (cycle_count=1).

Reset
REQ-031 With reset=1 at an edge, the FSM SHALL enter IDLE regardless of state, including mid-run.
REQ-032 That reset SHALL force proc_resetl=0, busy=0, done=0, pass=0, timeout=0, cycle_count=0, and clear the latched start_pc, end_pc and expected to 0.
REQ-033 reset SHALL take priority over start in the same cycle.

Structure
REQ-034 The state encoding, the default RESET_CYCLES value and the default WDOG_LIMIT value SHALL live in the shared package proc_ctrl_pkg.
REQ-035 The watchdog/cycle counter SHALL be one sub-module, run_watchdog, with clear, enable, limit and expired ports.
REQ-036 The top level SHALL instantiate no other sub-modules; the core is external.

Verification
REQ-037 Normal run: start_pc=0, end_pc=0x34, expected=0xF; currentpc model steps +4 per RUN cycle; dmemout=0xF -> done=1, pass=1, timeout=0, cycle_count=14.
REQ-038 Fail code: as REQ-037 but dmemout=0xE in SETTLE -> done=1, pass=0, timeout=0.
REQ-039 Hang: currentpc stuck at 0x10, end_pc=0x34 -> timeout=1, done=1, pass=0, cycle_count=0xFF, proc_resetl=0 afterwards.
REQ-040 Back-to-back runs:
- After REQ-037, start with start_pc=0x38, end_pc=0x70, expected=0x123456789abcdef0 and matching dmemout -> pass=1.
- A start pulse mid-run SHALL have no effect.
REQ-041 Tie: WDOG_LIMIT=4 and currentpc reaches end_pc on RUN cycle 4 -> SETTLE then DONE, timeout=0.
REQ-042 Reset mid-run: reset=1 at RUN cycle 5 -> next cycle IDLE, proc_resetl=0, all flags 0, cycle_count=0.
